// File: rtl/dsm_pkg.sv
// Shared constants for the MASH 1-1-1 delta-sigma modulator: output width,
// order encodings, dither LFSR taps and the legal output range.
package dsm_pkg;

  localparam int DO_W = 4;

  typedef enum logic [1:0] {
    ORD_BYP = 2'd0,
    ORD_1   = 2'd1,
    ORD_2   = 2'd2,
    ORD_3   = 2'd3
  } order_e;

  // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1 (bits 0,2,3,5).
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  localparam logic signed [DO_W-1:0] DO_MIN = -4'sd3;
  localparam logic signed [DO_W-1:0] DO_MAX = 4'sd4;

endpackage

// File: rtl/dsm_acc_stage.sv
// One first-order accumulator stage: WIDTH-bit wrap-around sum with carry out,
// advance enable and a synchronous clear that wins over the enable.
module dsm_acc_stage #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] addend,
  input  logic             cin,
  output logic [WIDTH-1:0] acc_nxt,
  output logic             carry
);

  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic [WIDTH:0]   sum;

  always_comb begin
    sum   = {1'b0, acc_q} + {1'b0, addend} + {{WIDTH{1'b0}}, cin};
    acc_d = acc_q;
    carry = 1'b0;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = sum[WIDTH-1:0];
      carry = sum[WIDTH];
    end
  end

  // The next value feeds the following stage in the same cycle.
  assign acc_nxt = acc_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/dsm_mash111.sv
// MASH 1-1-1 delta-sigma modulator with run-time order select, shadow-register
// load handshake and optional LFSR dither on the first stage LSB.
module dsm_mash111
  import dsm_pkg::*;
#(
  parameter int          WIDTH     = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] frac_in,
  input  logic [1:0]       order_in,
  input  logic             dither_in,
  input  logic             ld,
  output logic             ld_ack,
  output logic [DO_W-1:0]  DO,
  output logic             do_valid
);

  localparam logic signed [DO_W:0] Y_MIN = (DO_W+1)'(DO_MIN);
  localparam logic signed [DO_W:0] Y_MAX = (DO_W+1)'(DO_MAX);

  function automatic logic signed [DO_W:0] b2s(input logic b);
    return $signed({{DO_W{1'b0}}, b});
  endfunction

  function automatic logic signed [DO_W:0] combine(
    input order_e ord,
    input logic   k1,
    input logic   k2,
    input logic   k2d,
    input logic   k3,
    input logic   k3d,
    input logic   k3dd
  );
    logic signed [DO_W:0] s;
    s = '0;
    case (ord)
      ORD_1:   s = b2s(k1);
      ORD_2:   s = b2s(k1) + b2s(k2) - b2s(k2d);
      ORD_3:   s = b2s(k1) + b2s(k2) - b2s(k2d) + b2s(k3) - b2s(k3d) - b2s(k3d) + b2s(k3dd);
      default: s = '0;
    endcase
    return s;
  endfunction

  function automatic logic signed [DO_W-1:0] sat_do(input logic signed [DO_W:0] v);
    if (v < Y_MIN) return DO_MIN;
    if (v > Y_MAX) return DO_MAX;
    return v[DO_W-1:0];
  endfunction

  logic [WIDTH-1:0]       frac_q, frac_d, sh_frac_q, sh_frac_d, frac_nx, frac_eff;
  order_e                 order_q, order_d, sh_order_q, sh_order_d, order_nx, order_eff;
  logic                   dither_q, dither_d, sh_dither_q, sh_dither_d, dither_nx, dither_eff;
  logic                   pend_q, pend_d;
  logic                   ld_ack_q, ld_ack_d;
  logic                   do_valid_q, do_valid_d;
  logic signed [DO_W-1:0] do_q, do_d;
  logic [15:0]            lfsr_q, lfsr_d;
  logic                   c2d_q, c2d_d, c3d_q, c3d_d, c3dd_q, c3dd_d;
  logic                   xfer, ord_chg, run, dbit;
  logic [WIDTH-1:0]       acc1_nxt, acc2_nxt, acc3_nxt_unused;
  logic                   c1, c2, c3;
  logic signed [DO_W:0]   y;

  // A load coinciding with en bypasses the shadow so this cycle already uses it.
  always_comb begin
    xfer        = en & (pend_q | ld);
    frac_nx     = ld ? frac_in : sh_frac_q;
    order_nx    = ld ? order_e'(order_in) : sh_order_q;
    dither_nx   = ld ? dither_in : sh_dither_q;
    frac_eff    = xfer ? frac_nx : frac_q;
    order_eff   = xfer ? order_nx : order_q;
    dither_eff  = xfer ? dither_nx : dither_q;
    ord_chg     = xfer & (order_nx != order_q);
    run         = en & (order_eff != ORD_BYP);
    dbit        = dither_eff & lfsr_q[0];
    frac_d      = frac_eff;
    order_d     = order_eff;
    dither_d    = dither_eff;
    sh_frac_d   = frac_nx;
    sh_order_d  = order_nx;
    sh_dither_d = dither_nx;
    pend_d      = ~xfer & (pend_q | ld);
    ld_ack_d    = xfer;
  end

  dsm_acc_stage #(.WIDTH(WIDTH)) u_st1 (
    .clk     (clk),
    .rst     (rst),
    .en      (run),
    .clr     (1'b0),
    .addend  (frac_eff),
    .cin     (dbit),
    .acc_nxt (acc1_nxt),
    .carry   (c1)
  );

  dsm_acc_stage #(.WIDTH(WIDTH)) u_st2 (
    .clk     (clk),
    .rst     (rst),
    .en      (run),
    .clr     (ord_chg),
    .addend  (acc1_nxt),
    .cin     (1'b0),
    .acc_nxt (acc2_nxt),
    .carry   (c2)
  );

  dsm_acc_stage #(.WIDTH(WIDTH)) u_st3 (
    .clk     (clk),
    .rst     (rst),
    .en      (run),
    .clr     (ord_chg),
    .addend  (acc2_nxt),
    .cin     (1'b0),
    .acc_nxt (acc3_nxt_unused),
    .carry   (c3)
  );

  // An order change restarts the noise-shaping stages, so their delays read as zero.
  always_comb begin
    lfsr_d = en ? {^(lfsr_q & LFSR_TAPS), lfsr_q[15:1]} : lfsr_q;
    c2d_d  = c2d_q;
    c3d_d  = c3d_q;
    c3dd_d = c3dd_q;
    if (ord_chg) begin
      c2d_d  = 1'b0;
      c3d_d  = 1'b0;
      c3dd_d = 1'b0;
    end else if (run) begin
      c2d_d  = c2;
      c3d_d  = c3;
      c3dd_d = c3d_q;
    end
    y = combine(order_eff, c1, c2, c2d_q & ~ord_chg, c3, c3d_q & ~ord_chg,
                c3dd_q & ~ord_chg);
    do_d = do_q;
    if (run) begin
      do_d = sat_do(y);
    end else if (en) begin
      do_d = '0;
    end
    do_valid_d = en;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frac_q      <= '0;
      order_q     <= ORD_BYP;
      dither_q    <= 1'b0;
      sh_frac_q   <= '0;
      sh_order_q  <= ORD_BYP;
      sh_dither_q <= 1'b0;
      pend_q      <= 1'b0;
      ld_ack_q    <= 1'b0;
      do_valid_q  <= 1'b0;
      do_q        <= '0;
      lfsr_q      <= LFSR_SEED;
      c2d_q       <= 1'b0;
      c3d_q       <= 1'b0;
      c3dd_q      <= 1'b0;
    end else begin
      frac_q      <= frac_d;
      order_q     <= order_d;
      dither_q    <= dither_d;
      sh_frac_q   <= sh_frac_d;
      sh_order_q  <= sh_order_d;
      sh_dither_q <= sh_dither_d;
      pend_q      <= pend_d;
      ld_ack_q    <= ld_ack_d;
      do_valid_q  <= do_valid_d;
      do_q        <= do_d;
      lfsr_q      <= lfsr_d;
      c2d_q       <= c2d_d;
      c3d_q       <= c3d_d;
      c3dd_q      <= c3dd_d;
    end
  end

  assign ld_ack   = ld_ack_q;
  assign DO       = do_q;
  assign do_valid = do_valid_q;

endmodule

// File: tb/tb_dsm_mash111.sv
// Bench for dsm_mash111: an integer reference model queues the expected DO of
// every en edge, directed steps add handshake, boundary and statistics checks.
module tb_dsm_mash111;

  logic        clk;
  logic        rst;
  logic        en;
  logic [15:0] frac_in;
  logic [1:0]  order_in;
  logic        dither_in;
  logic        ld;
  logic        ld_ack;
  logic [3:0]  DO;
  logic        do_valid;

  int n_assert = 0;
  int n_fail   = 0;

  dsm_mash111 #(.WIDTH(16), .LFSR_SEED(16'hACE1)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .frac_in   (frac_in),
    .order_in  (order_in),
    .dither_in (dither_in),
    .ld        (ld),
    .ld_ack    (ld_ack),
    .DO        (DO),
    .do_valid  (do_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_range(input string tag, input int obs, input int lo, input int hi);
    n_assert++;
    assert (obs >= lo && obs <= hi) else begin
      n_fail++;
      $error("FAIL %s: observed %0d required %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Reference model of the spec equations, evaluated on every clock edge.
  logic [15:0] m_a1, m_a2, m_a3, m_frac, s_frac, m_lfsr;
  logic [1:0]  m_ord, s_ord;
  logic        m_dith, s_dith, m_pend, m_ack, m_vld, m_xfer, m_chg;
  logic [16:0] m_s;
  int          m1, m2, m3, m_y, m_c2d, m_c3d, m_c3dd;
  int          sb[$];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_a1 = 0; m_a2 = 0; m_a3 = 0;
      m_c2d = 0; m_c3d = 0; m_c3dd = 0;
      m_frac = 0; m_ord = 0; m_dith = 0;
      s_frac = 0; s_ord = 0; s_dith = 0;
      m_pend = 0; m_ack = 0; m_vld = 0;
      m_lfsr = 16'hACE1;
      sb.delete();
    end else begin
      m_xfer = en && (m_pend || ld);
      if (ld) begin
        s_frac = frac_in; s_ord = order_in; s_dith = dither_in;
      end
      m_chg = 1'b0;
      if (m_xfer) begin
        m_chg  = (s_ord != m_ord);
        m_frac = s_frac; m_ord = s_ord; m_dith = s_dith;
        m_pend = 1'b0;
      end else if (ld) begin
        m_pend = 1'b1;
      end
      m_ack = m_xfer;
      m_vld = en;
      if (m_chg) begin
        m_a2 = 0; m_a3 = 0; m_c2d = 0; m_c3d = 0; m_c3dd = 0;
      end
      if (en) begin
        if (m_ord == 2'd0) begin
          sb.push_back(0);
        end else begin
          m_s  = {1'b0, m_a1} + {1'b0, m_frac} + {16'd0, (m_dith & m_lfsr[0])};
          m1   = int'(m_s[16]);
          m_a1 = m_s[15:0];
          if (m_chg) begin
            m2 = 0; m3 = 0;
          end else begin
            m_s = {1'b0, m_a2} + {1'b0, m_a1}; m2 = int'(m_s[16]); m_a2 = m_s[15:0];
            m_s = {1'b0, m_a3} + {1'b0, m_a2}; m3 = int'(m_s[16]); m_a3 = m_s[15:0];
          end
          case (m_ord)
            2'd1:    m_y = m1;
            2'd2:    m_y = m1 + m2 - m_c2d;
            default: m_y = m1 + m2 - m_c2d + m3 - 2 * m_c3d + m_c3dd;
          endcase
          sb.push_back(m_y);
          if (!m_chg) begin
            m_c3dd = m_c3d; m_c3d = m3; m_c2d = m2;
          end
        end
        m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
      end
    end
  end

  int exp_do;

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      chk("do_valid", 32'(do_valid), 32'(m_vld));
      chk("ld_ack", 32'(ld_ack), 32'(m_ack));
      if (do_valid === 1'b1) begin
        chk("scoreboard_not_empty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          exp_do = sb.pop_front();
          chk("do_value", 32'($signed(DO)), exp_do);
        end
      end
    end
  end

  int sum, mn, mx, nz, v;
  logic [3:0] hold_do;

  task automatic stats_clear();
    sum = 0; mn = 100; mx = -100; nz = 0;
  endtask

  task automatic stats_add();
    v = $signed(DO);
    sum += v;
    if (v < mn) mn = v;
    if (v > mx) mx = v;
    if (v != 0) nz++;
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; ld = 1'b0;
    frac_in = '0; order_in = '0; dither_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_do", 32'(DO), 32'd0);
    chk("reset_do_valid", 32'(do_valid), 32'd0);
    chk("reset_ld_ack", 32'(ld_ack), 32'd0);
    chk("reset_lfsr", 32'(dut.lfsr_q), 32'hACE1);

    // Order 1, half scale: 0,1,0,1...
    rst = 1'b1; ld = 1'b1; frac_in = 16'h8000; order_in = 2'd1; en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      ld = 1'b0;
      chk("half_scale_seq", 32'(DO), 32'(i % 2));
      if (i == 0) begin
        chk("half_ld_ack_pulse", 32'(ld_ack), 32'd1);
        chk("half_do_valid", 32'(do_valid), 32'd1);
      end
      if (i == 1) chk("half_ld_ack_drop", 32'(ld_ack), 32'd0);
    end

    // Order 3, quarter scale.
    ld = 1'b1; frac_in = 16'h4000; order_in = 2'd3;
    stats_clear();
    for (int i = 0; i < 16384; i++) begin
      @(negedge clk);
      ld = 1'b0;
      stats_add();
    end
    chk_range("ord3_quarter_sum", sum, 4094, 4098);
    chk_range("ord3_min", mn, -3, 4);
    chk_range("ord3_max", mx, -3, 4);

    // Zero input from a clean reset.
    rst = 1'b0; en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1; ld = 1'b1; frac_in = 16'h0000; order_in = 2'd3; dither_in = 1'b0; en = 1'b1;
    stats_clear();
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      ld = 1'b0;
      stats_add();
    end
    chk("zero_frac_nonzero_count", 32'(nz), 32'd0);

    // All-ones input, order 2.
    ld = 1'b1; frac_in = 16'hFFFF; order_in = 2'd2;
    stats_clear();
    for (int i = 0; i < 8192; i++) begin
      @(negedge clk);
      ld = 1'b0;
      stats_add();
    end
    chk_range("ones_ord2_sum", sum, 8190, 8192);
    chk_range("ones_min", mn, -3, 4);
    chk_range("ones_max", mx, -3, 4);

    // Load while idle: nothing moves until en.
    en = 1'b0; ld = 1'b1; frac_in = 16'h1234; order_in = 2'd1;
    hold_do = DO;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      ld = 1'b0;
      chk("idle_no_ack", 32'(ld_ack), 32'd0);
      chk("idle_frac_kept", 32'(dut.frac_q), 32'hFFFF);
    end
    chk("idle_do_hold", 32'(DO), 32'(hold_do));
    chk("idle_order_kept", 32'(dut.order_q), 32'd2);
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    chk("xfer_ack", 32'(ld_ack), 32'd1);
    chk("xfer_frac", 32'(dut.frac_q), 32'h1234);
    chk("xfer_order", 32'(dut.order_q), 32'd1);
    @(negedge clk);
    chk("xfer_ack_drop", 32'(ld_ack), 32'd0);

    // Two loads before en: last one wins.
    ld = 1'b1; frac_in = 16'h1111; order_in = 2'd2;
    @(negedge clk);
    frac_in = 16'h2222; order_in = 2'd3;
    @(negedge clk);
    ld = 1'b0; en = 1'b1;
    @(negedge clk);
    chk("last_wins_frac", 32'(dut.frac_q), 32'h2222);
    chk("last_wins_order", 32'(dut.order_q), 32'd3);
    repeat (20) @(negedge clk);
    chk("acc2_running", 32'(dut.u_st2.acc_q != 16'd0), 32'd1);

    // Order 3 -> 1 clears the upper stages but keeps acc1.
    ld = 1'b1; frac_in = 16'h3000; order_in = 2'd1;
    @(negedge clk);
    ld = 1'b0;
    chk("chg_acc2_clear", 32'(dut.u_st2.acc_q), 32'd0);
    chk("chg_acc3_clear", 32'(dut.u_st3.acc_q), 32'd0);
    chk("chg_acc1_kept", 32'(dut.u_st1.acc_q), 32'(m_a1));

    // Dither on a zero input.
    ld = 1'b1; frac_in = 16'h0000; order_in = 2'd3; dither_in = 1'b1;
    stats_clear();
    for (int i = 0; i < 8192; i++) begin
      @(negedge clk);
      ld = 1'b0;
      stats_add();
    end
    chk_range("dither_sum", sum, -81, 81);
    chk("dither_nonconstant", 32'(mx != mn), 32'd1);
    chk_range("dither_min", mn, -3, 4);
    chk_range("dither_max", mx, -3, 4);

    // Asynchronous reset with a load pending.
    en = 1'b0; ld = 1'b1; frac_in = 16'h5555; order_in = 2'd1; dither_in = 1'b0;
    @(negedge clk);
    ld = 1'b0;
    chk("pending_set", 32'(dut.pend_q), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("async_do", 32'(DO), 32'd0);
    chk("async_do_valid", 32'(do_valid), 32'd0);
    chk("async_ld_ack", 32'(ld_ack), 32'd0);
    chk("async_lfsr_seed", 32'(dut.lfsr_q), 32'hACE1);
    chk("async_pending_clear", 32'(dut.pend_q), 32'd0);
    @(negedge clk);
    rst = 1'b1; en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_reset_no_ack", 32'(ld_ack), 32'd0);
      chk("post_reset_do", 32'(DO), 32'd0);
    end
    chk("post_reset_bypass", 32'(dut.order_q), 32'd0);
    chk("post_reset_lfsr", 32'(dut.lfsr_q), 32'(m_lfsr));
    en = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/dsm_mash111.md
Name: dsm_mash111

Overview:
- Parametrised MASH 1-1-1 delta-sigma modulator; successor to the first-order single-bit DSM.
- Converts an unsigned fractional word into a multi-bit signed integer stream whose long-term mean is frac/2^WIDTH.
- Drives the fractional-N divider-modulus offset in the PLL feedback path.
- Order is selectable at run time (1/2/3). Optional LFSR dither breaks idle tones.

Parameters:
- WIDTH, 16: accumulator and fractional-input width in bits, 8..24.
- LFSR_SEED, 16'hACE1: non-zero dither LFSR seed, loaded at reset.

Ports:
- clk  in  1  modulator clock (divider output clock).
- rst  in  1  reset, asynchronous, active-low.
- en  in  1  advance enable; modulator state updates only on clk edges with en=1.
- frac_in  in  WIDTH  unsigned fractional word.
- order_in  in  2  requested order: 1, 2 or 3; 0 = bypass.
- dither_in  in  1  dither enable request.
- ld  in  1  load strobe; captures frac_in/order_in/dither_in.
- ld_ack  out  1  one-cycle pulse: the loaded settings are now in effect.
- DO  out  4  signed modulus offset, range -3..+4.
- do_valid  out  1  pulses one cycle after each en cycle.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - On rst=0 (asynchronous), all of the following clear: acc1..3, carry delay lines, frac_r, order_r, dither_r, the pending-load flag, ld_ack, DO and do_valid. The LFSR loads LFSR_SEED.
  - Reset mid-operation discards any pending load.
- Load handshake:
  - ld=1 on any edge sets a pending flag and latches the inputs into shadow registers. A later ld overwrites the shadow values (last wins).
  - Shadow values transfer to frac_r/order_r/dither_r on the next edge with en=1.
  - ld_ack pulses on the edge after that transfer.
  - If ld and en are both 1 on the same edge, the transfer happens on that edge. That en cycle already uses the new values, and ld_ack pulses on the following edge.
  - If order changes, acc2, acc3 and all carry delays clear on the transfer edge. acc1 is kept.
- Datapath, per en edge:
  - d = dither_r ? lfsr[0] : 0.
  - {c1,acc1} = acc1 + frac_r + d.
  - {c2,acc2} = acc2 + acc1_next.
  - {c3,acc3} = acc3 + acc2_next.
  - All sums are WIDTH+1 bits; the carry is the MSB; accumulators wrap modulo 2^WIDTH.
  - Delay regs: c2d <= c2, c3d <= c3, c3dd <= c3d.
  - LFSR: 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1. Steps every en edge regardless of dither_r.
- Output combine, 4-bit signed:
  - order 1: y = c1.
  - order 2: y = c1 + c2 - c2d.
  - order 3: y = c1 + c2 - c2d + c3 - 2*c3d + c3dd.
  - order 0: y = 0, and accumulators hold.
- Output registering:
  - DO <= y on the en edge; latency is one clock from that edge.
  - do_valid <= en.
  - When en=0, DO holds, do_valid=0, and all state holds.
- Boundary conditions:
  - frac_r=0 with no dither gives DO=0 permanently.
  - frac_r=2^WIDTH-1 has mean (2^WIDTH-1)/2^WIDTH; no overflow beyond the carry.
  - DO is always within -3..+4.

Decomposition:
- Package dsm_pkg holds:
  - the DO width constant (4);
  - the order encodings ORD_BYP=0, ORD_1=1, ORD_2=2, ORD_3=3;
  - the LFSR tap mask;
  - the DO_MIN=-3 and DO_MAX=4 constants.
- One sub-module, dsm_acc_stage: a WIDTH-bit accumulator with enable, synchronous clear and carry out. It is instantiated three times.
- Load handshake, LFSR and output combine stay in the top.

Test Plan:
- Reset to 0: after reset, order 1, frac=16'h8000, no dither, en=1 continuous -> DO sequence 0,1,0,1,...; do_valid=1 from the second edge.
- Order 3, frac=16'h4000, no dither, 65536 en cycles -> DO sum = 16384 ±2; every DO in -3..+4; no tone shorter than period 4 beyond expected.
- Zero/all-ones inputs:
  - frac=0, order 3, no dither -> DO=0 for 1000 cycles.
  - frac=16'hFFFF, order 2 -> sum over 65536 cycles = 65535 ±1.
- Load handshake:
  - ld pulse with en=0 for 5 cycles -> no ld_ack and settings unchanged; first en edge transfers; ld_ack pulses the next edge.
  - Two ld pulses before en -> second value wins.
  - Order change 3->1 clears acc2/acc3 (checked via hierarchical probe).
- Dither and reset:
  - Dither on, frac=0, order 3 -> DO non-constant, mean -> 0 within ±0.01 over 2^16 cycles.
  - Assert rst mid-run -> all outputs 0 immediately and no ld_ack pending after release; LFSR restarts from 16'hACE1.
